// File: rtl/bpred_ctrl_d.sv
// bpred_ctrl_d -- decode-stage control-flow unit with a direct-mapped BTB.
//
// Resolves branches and jumps in D and predicts taken/target in F. It also
// keeps the existing D-stage duties: extender select and jump-source select.
//
// Optional feature macro: BPRED_STATS_EN adds the br_cnt/miss_cnt counters.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   pc_f              fetch PC used for the BTB lookup
//   pred_taken_f      BTB hit and counter MSB set
//   pred_target_f     stored target on a hit, 0 otherwise
//   valid_d, stall_d  D holds a real instruction / D frozen this cycle
//   ir_d, pc_d        D instruction and its PC
//   rs_val_d          forwarded rs value (jr/jalr target)
//   ab_cmp, a0_cmp    rs-vs-rt and rs-vs-0 flags: [2] gt, [1] eq, [0] lt
//   ext_sel           sign-extend select (lw, sw, slti, sltiu)
//   b_j_jr_sel        2 = jr/jalr, 1 = j/jal, 0 = other
//   redirect_d        override next fetch PC and flush F
//   redirect_pc_d     architecturally correct next PC for the D instruction
//   br_cnt, miss_cnt  (BPRED_STATS_EN only) resolved control-flow / redirects
//
// Valid/ready: there is no handshake. An instruction resolves in a cycle
// where valid_d=1 and stall_d=0. Redirects and BTB writes happen only then.
module bpred_ctrl_d #(
    parameter int IDX_W = 6,
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_f,
    output logic        pred_taken_f,
    output logic [31:0] pred_target_f,
    input  logic        valid_d,
    input  logic        stall_d,
    input  logic [31:0] ir_d,
    input  logic [31:0] pc_d,
    input  logic [31:0] rs_val_d,
    input  logic [2:0]  ab_cmp,
    input  logic [2:0]  a0_cmp,
    output logic        ext_sel,
    output logic [1:0]  b_j_jr_sel,
    output logic        redirect_d,
    output logic [31:0] redirect_pc_d
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int N     = 1 << IDX_W;
    localparam int TAG_W = 32 - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_WT  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_RST = {1'b0, {(CNT_W-1){1'b1}}};

    // BTB storage
    logic             valid_q [N];
    logic [TAG_W-1:0] tag_q   [N];
    logic [31:0]      tgt_q   [N];
    logic [CNT_W-1:0] cnt_q   [N];

    // F-to-D prediction register
    logic        pred_d_q;
    logic [31:0] ptgt_d_q;

    // ---------------- F-stage lookup ----------------
    logic [IDX_W-1:0] f_idx;
    logic             f_hit;
    assign f_idx = pc_f[IDX_W+1:2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == pc_f[31:IDX_W+2]);
    assign pred_taken_f  = f_hit && cnt_q[f_idx][CNT_W-1];
    assign pred_target_f = f_hit ? tgt_q[f_idx] : 32'd0;

    // ---------------- D-stage decode ----------------
    logic [5:0]  op, funct;
    logic [4:0]  rt;
    logic [15:0] imm;
    assign op    = ir_d[31:26];
    assign rt    = ir_d[20:16];
    assign funct = ir_d[5:0];
    assign imm   = ir_d[15:0];

    logic is_beq, is_bne, is_blez, is_bgtz, is_bltz, is_bgez;
    logic is_j, is_jr, is_cond, is_cf;
    assign is_beq  = (op == 6'd4);
    assign is_bne  = (op == 6'd5);
    assign is_blez = (op == 6'd6);
    assign is_bgtz = (op == 6'd7);
    assign is_bltz = (op == 6'd1) && (rt == 5'd0);
    assign is_bgez = (op == 6'd1) && (rt == 5'd1);
    assign is_j    = (op == 6'd2) || (op == 6'd3);
    assign is_jr   = (op == 6'd0) && ((funct == 6'd8) || (funct == 6'd9));
    assign is_cond = is_beq | is_bne | is_blez | is_bgtz | is_bltz | is_bgez;
    assign is_cf   = is_cond | is_j | is_jr;

    assign ext_sel    = (op == 6'd35) || (op == 6'd43) || (op == 6'd10) || (op == 6'd11);
    assign b_j_jr_sel = is_jr ? 2'd2 : (is_j ? 2'd1 : 2'd0);

    // Only the eq flag of ab_cmp matters (beq/bne); pc_f[1:0] is not an index bit.
    logic unused_ok;
    assign unused_ok = ^{ab_cmp[2], ab_cmp[0], pc_f[1:0]};

    logic cond_taken;
    assign cond_taken = (is_beq  &  ab_cmp[1])
                      | (is_bne  & ~ab_cmp[1])
                      | (is_bgez & (a0_cmp[2] | a0_cmp[1]))
                      | (is_bgtz &  a0_cmp[2])
                      | (is_blez & (a0_cmp[0] | a0_cmp[1]))
                      | (is_bltz &  a0_cmp[0]);

    logic [31:0] seq_pc, br_tgt, j_tgt, act_tgt;
    logic        act_taken;
    assign seq_pc    = pc_d + 32'd4;
    assign br_tgt    = seq_pc + {{14{imm[15]}}, imm, 2'b00};
    assign j_tgt     = {pc_d[31:28], ir_d[25:0], 2'b00};
    assign act_tgt   = is_jr ? rs_val_d : (is_j ? j_tgt : br_tgt);
    assign act_taken = cond_taken | is_j | is_jr;

    assign redirect_pc_d = act_taken ? act_tgt : seq_pc;

    // jr/jalr never live in the BTB, so they always redirect.
    logic mispred, resolve;
    assign mispred = (is_cond & (cond_taken != pred_d_q))
                   | (act_taken & (ptgt_d_q != act_tgt))
                   | (is_j & ~pred_d_q)
                   | is_jr
                   | (~is_cf & pred_d_q);
    assign resolve    = valid_d & ~stall_d;
    assign redirect_d = rst_n & resolve & mispred;

    // ---------------- BTB update ----------------
    logic [IDX_W-1:0] d_idx;
    logic [TAG_W-1:0] d_tag;
    logic             d_hit;
    assign d_idx = pc_d[IDX_W+1:2];
    assign d_tag = pc_d[31:IDX_W+2];
    assign d_hit = valid_q[d_idx] && (tag_q[d_idx] == d_tag);

    logic             upd_en, upd_valid;
    logic [31:0]      upd_tgt;
    logic [CNT_W-1:0] upd_cnt;

    always_comb begin
        upd_en    = 1'b0;
        upd_valid = valid_q[d_idx];
        upd_tgt   = tgt_q[d_idx];
        upd_cnt   = cnt_q[d_idx];
        if (resolve) begin
            if (is_cond) begin
                if (d_hit) begin
                    upd_en    = 1'b1;
                    upd_valid = 1'b1;
                    upd_tgt   = br_tgt;
                    if (cond_taken)
                        upd_cnt = (cnt_q[d_idx] == CNT_MAX) ? CNT_MAX : cnt_q[d_idx] + CNT_ONE;
                    else
                        upd_cnt = (cnt_q[d_idx] == '0) ? '0 : cnt_q[d_idx] - CNT_ONE;
                end else if (cond_taken) begin
                    upd_en    = 1'b1;
                    upd_valid = 1'b1;
                    upd_tgt   = br_tgt;
                    upd_cnt   = CNT_WT;
                end
            end else if (is_j) begin
                upd_en    = 1'b1;
                upd_valid = 1'b1;
                upd_tgt   = j_tgt;
                upd_cnt   = CNT_MAX;
            end else if (!is_jr && pred_d_q && d_hit) begin
                // Stale entry predicted a non-branch as taken: drop it.
                upd_en    = 1'b1;
                upd_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                cnt_q[i]   <= CNT_RST;
            end
        end else if (upd_en) begin
            valid_q[d_idx] <= upd_valid;
            tag_q[d_idx]   <= d_tag;
            tgt_q[d_idx]   <= upd_tgt;
            cnt_q[d_idx]   <= upd_cnt;
        end
    end

    // A redirect flushes F, so the prediction entering D becomes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_d_q <= 1'b0;
            ptgt_d_q <= '0;
        end else if (redirect_d) begin
            pred_d_q <= 1'b0;
            ptgt_d_q <= '0;
        end else if (!stall_d) begin
            pred_d_q <= pred_taken_f;
            ptgt_d_q <= pred_target_f;
        end
    end

`ifdef BPRED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else begin
            if (resolve && is_cf) br_cnt <= br_cnt + 32'd1;
            if (redirect_d)       miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bpred_ctrl_d.sv
module tb_bpred_ctrl_d;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pc_f, ir_d, pc_d, rs_val_d, pred_target_f, redirect_pc_d;
  logic        pred_taken_f, valid_d, stall_d, ext_sel, redirect_d;
  logic [2:0]  ab_cmp, a0_cmp;
  logic [1:0]  b_j_jr_sel;
`ifdef BPRED_STATS_EN
  logic [31:0] br_cnt, miss_cnt;
`endif

  bpred_ctrl_d #(.IDX_W(6), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .pc_f(pc_f),
    .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
    .valid_d(valid_d), .stall_d(stall_d), .ir_d(ir_d), .pc_d(pc_d),
    .rs_val_d(rs_val_d), .ab_cmp(ab_cmp), .a0_cmp(a0_cmp),
    .ext_sel(ext_sel), .b_j_jr_sel(b_j_jr_sel),
`ifdef BPRED_STATS_EN
    .br_cnt(br_cnt), .miss_cnt(miss_cnt),
`endif
    .redirect_d(redirect_d), .redirect_pc_d(redirect_pc_d)
  );

  localparam logic [31:0] DUMMY = 32'h0000_0800;  // never allocated
  localparam logic [31:0] BEQ4  = 32'h1022_0004;  // beq r1,r2,+4
  localparam logic [31:0] BNE8  = 32'h1422_0008;  // bne r1,r2,+8
  localparam logic [31:0] JAL   = 32'h0C00_0C80;  // jal idx26=0xC80
  localparam logic [31:0] JR4   = 32'h0080_0008;  // jr r4
  localparam logic [31:0] ADD   = 32'h0043_0820;  // add r1,r2,r3
  localparam logic [2:0]  GT = 3'b100, EQ = 3'b010, LT = 3'b001;

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic sb_pop(input string tag, input logic [32:0] got);
    logic [32:0] exp;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    check_eq(tag, {31'd0, got}, {31'd0, exp});
  endtask

  // ---------------- drivers ----------------
  task automatic fetch(input logic [31:0] pc);
    valid_d = 1'b0;
    stall_d = 1'b0;
    pc_f = pc;
    @(posedge clk); #1;
  endtask

  // One unstalled D cycle; compares {redirect_d, redirect_pc_d}.
  task automatic resolve_d(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                           input logic [31:0] rs, input logic [2:0] ab, input logic [2:0] a0,
                           input logic exp_red, input logic [31:0] exp_pc);
    pc_f = DUMMY;
    valid_d = 1'b1;
    stall_d = 1'b0;
    ir_d = ir; pc_d = pc; rs_val_d = rs; ab_cmp = ab; a0_cmp = a0;
    exp_q.push_back({exp_red, exp_pc});
    @(negedge clk);
    sb_pop(tag, {redirect_d, redirect_pc_d});
    @(posedge clk); #1;
    valid_d = 1'b0;
  endtask

  // F-side lookup; compares {pred_taken_f, pred_target_f}.
  task automatic probe(input string tag, input logic [31:0] pc,
                       input logic exp_tk, input logic [31:0] exp_tgt);
    valid_d = 1'b0;
    pc_f = pc;
    exp_q.push_back({exp_tk, exp_tgt});
    @(negedge clk);
    sb_pop(tag, {pred_taken_f, pred_target_f});
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus tables ----------------
  logic [31:0] dec_ir  [9] = '{32'h8C00_0000, 32'hAC00_0000, 32'h2800_0000, 32'h2C00_0000,
                               32'h3400_0000, 32'h0800_0000, 32'h0000_0009, 32'h0000_0020,
                               32'h1000_0000};
  logic        dec_ext [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
  logic [1:0]  dec_sel [9] = '{0, 0, 0, 0, 0, 1, 2, 0, 0};

  // Other conditional types, cold BTB, imm = -4 so taken target = pc - 12.
  logic [31:0] cb_ir  [7] = '{32'h1C60_FFFC, 32'h1860_FFFC, 32'h1860_FFFC, 32'h0460_FFFC,
                              32'h0461_FFFC, 32'h0461_FFFC, 32'h1422_FFFC};
  logic [2:0]  cb_a0  [7] = '{GT, EQ, GT, LT, LT, EQ, EQ};
  logic [2:0]  cb_ab  [7] = '{EQ, EQ, EQ, EQ, EQ, EQ, LT};
  logic        cb_tk  [7] = '{1, 1, 0, 1, 0, 1, 1};

  initial begin
    logic [31:0] pc;
    pc_f = 32'h0000_3000; valid_d = 1'b1; stall_d = 1'b0;
    ir_d = JR4; pc_d = 32'h0000_3308; rs_val_d = 32'h1234_5678;
    ab_cmp = '0; a0_cmp = '0;

    // Reset state: predictions/redirect quiet, decode outputs follow inputs.
    #2;
    check_eq("rst_redirect", {63'd0, redirect_d}, 64'd0);
    check_eq("rst_pred_taken", {63'd0, pred_taken_f}, 64'd0);
    check_eq("rst_pred_target", {32'd0, pred_target_f}, 64'd0);
    check_eq("rst_redirect_pc", {32'd0, redirect_pc_d}, 64'h1234_5678);
    check_eq("rst_b_j_jr_sel", {62'd0, b_j_jr_sel}, 64'd2);
    valid_d = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Decode selects.
    for (int i = 0; i < 9; i++) begin
      ir_d = dec_ir[i];
      #1;
      check_eq($sformatf("ext_sel_%0d", i), {63'd0, ext_sel}, {63'd0, dec_ext[i]});
      check_eq($sformatf("bjjr_sel_%0d", i), {62'd0, b_j_jr_sel}, {62'd0, dec_sel[i]});
    end

    // Cold start.
    fetch(32'h0000_3000);
    resolve_d("cold_beq", BEQ4, 32'h0000_3000, $urandom, EQ, 3'($urandom_range(0, 7)), 1'b1, 32'h0000_3014);
    probe("cold_lookup", 32'h0000_3000, 1'b1, 32'h0000_3014);

    // Saturation upward: four correct taken predictions.
    for (int i = 0; i < 4; i++) begin
      fetch(32'h0000_3000);
      resolve_d($sformatf("sat_taken_%0d", i), BEQ4, 32'h0000_3000, $urandom, EQ,
                3'($urandom_range(0, 7)), 1'b0, 32'h0000_3014);
    end
`ifdef BPRED_STATS_EN
    check_eq("stats_br_cnt", {32'd0, br_cnt}, 64'd5);
    check_eq("stats_miss_cnt", {32'd0, miss_cnt}, 64'd1);
`endif

    // Downward 3->2->1->0: only the first, predicted taken, redirects.
    fetch(32'h0000_3000);
    resolve_d("nt_3to2", BEQ4, 32'h0000_3000, $urandom, LT, 3'($urandom_range(0, 7)), 1'b1, 32'h0000_3004);
    resolve_d("nt_2to1", BEQ4, 32'h0000_3000, $urandom, GT, 3'($urandom_range(0, 7)), 1'b0, 32'h0000_3004);
    resolve_d("nt_1to0", BEQ4, 32'h0000_3000, $urandom, LT, 3'($urandom_range(0, 7)), 1'b0, 32'h0000_3004);
    resolve_d("nt_hold0", BEQ4, 32'h0000_3000, $urandom, LT, 3'($urandom_range(0, 7)), 1'b0, 32'h0000_3004);
    resolve_d("tk_0to1", BEQ4, 32'h0000_3000, $urandom, EQ, 3'($urandom_range(0, 7)), 1'b1, 32'h0000_3014);
    probe("cnt1_lookup", 32'h0000_3000, 1'b0, 32'h0000_3014);
    fetch(32'h0000_3000);
    resolve_d("tk_1to2", BEQ4, 32'h0000_3000, $urandom, EQ, 3'($urandom_range(0, 7)), 1'b1, 32'h0000_3014);
    probe("cnt2_lookup", 32'h0000_3000, 1'b1, 32'h0000_3014);

    // Not-taken miss: no redirect, no allocation.
    fetch(32'h0000_3204);
    resolve_d("bne_nt", BNE8, 32'h0000_3204, $urandom, EQ, 3'($urandom_range(0, 7)), 1'b0, 32'h0000_3208);
    probe("bne_no_alloc", 32'h0000_3204, 1'b0, 32'h0000_0000);

    // jal: miss then hit; overwrites the beq entry sharing index 0.
    fetch(32'h0000_3100);
    resolve_d("jal_first", JAL, 32'h0000_3100, $urandom, 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 1'b1, 32'h0000_3200);
    fetch(32'h0000_3100);
    resolve_d("jal_second", JAL, 32'h0000_3100, $urandom, 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 1'b0, 32'h0000_3200);
    probe("beq_evicted", 32'h0000_3000, 1'b0, 32'h0000_0000);

    // jr: always redirect, never allocated.
    for (int i = 0; i < 2; i++) begin
      fetch(32'h0000_3308);
      resolve_d($sformatf("jr_%0d", i), JR4, 32'h0000_3308, 32'h0000_3400, 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 1'b1, 32'h0000_3400);
    end
    probe("jr_no_alloc", 32'h0000_3308, 1'b0, 32'h0000_0000);

    // Non-branch at a predicted-taken PC: redirect to pc+4 and drop entry.
    fetch(32'h0000_3100);
    resolve_d("alu_falsepred", ADD, 32'h0000_3100, $urandom, 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 1'b1, 32'h0000_3104);
    probe("alu_entry_cleared", 32'h0000_3100, 1'b0, 32'h0000_0000);

    // Random non-branches at cold PCs never redirect.
    for (int i = 0; i < 4; i++) begin
      pc = 32'h0000_5000 + 32'($urandom_range(0, 255)) * 4;
      resolve_d($sformatf("alu_rand_%0d", i), ADD, pc, $urandom, 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 1'b0, pc + 32'd4);
    end

    // Stall: a mispredicting beq held for 3 cycles.
    fetch(32'h0000_3010);
    valid_d = 1'b1; stall_d = 1'b1; pc_f = 32'h0000_3010;
    ir_d = BEQ4; pc_d = 32'h0000_3010; ab_cmp = EQ; a0_cmp = 3'($urandom_range(0, 7));
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 32'h0000_3024});
      @(negedge clk);
      sb_pop($sformatf("stall_redirect_%0d", i), {redirect_d, redirect_pc_d});
      check_eq($sformatf("stall_no_update_%0d", i), {63'd0, pred_taken_f}, 64'd0);
      @(posedge clk); #1;
    end
    stall_d = 1'b0;
    exp_q.push_back({1'b1, 32'h0000_3024});
    @(negedge clk);
    sb_pop("unstall_redirect", {redirect_d, redirect_pc_d});
    @(posedge clk); #1;
    valid_d = 1'b0;
    probe("unstall_alloc", 32'h0000_3010, 1'b1, 32'h0000_3024);

    // Other conditional kinds from a cold BTB.
    for (int i = 0; i < 7; i++) begin
      pc = 32'h0000_6040 + 32'(i) * 32'h20;
      fetch(pc);
      resolve_d($sformatf("cond_kind_%0d", i), cb_ir[i], pc, $urandom, cb_ab[i], cb_a0[i],
                cb_tk[i], cb_tk[i] ? pc - 32'd12 : pc + 32'd4);
    end

    // Mid-stream asynchronous reset wipes the BTB at once.
    pc_f = 32'h0000_3010; valid_d = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_pred_taken", {63'd0, pred_taken_f}, 64'd0);
    check_eq("midrst_pred_target", {32'd0, pred_target_f}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    probe("post_rst_lookup", 32'h0000_3010, 1'b0, 32'h0000_0000);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bpred_ctrl_d.md
# bpred_ctrl_d

Decode-stage control-flow unit for the no-delay-slot core variant. It keeps the existing D-stage duties: branch resolution from the comparator flags, extender select, and jump-source select. It adds a parametrised direct-mapped branch target buffer (BTB) with saturating counters, so the fetch stage can redirect speculatively. D-stage resolution then either confirms the prediction or issues a one-cycle flush and redirect.

## Interface
- IDX_W, 6: BTB index bits; 2^IDX_W entries, indexed by PC[IDX_W+1:2].
- CNT_W, 2: saturating counter width, minimum 2.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_f  in  32  fetch PC used for lookup.
- pred_taken_f  out  1  BTB hit and counter MSB set.
- pred_target_f  out  32  stored target; 0 when no hit.
- valid_d  in  1  D holds a real instruction.
- stall_d  in  1  D frozen this cycle.
- ir_d  in  32  D instruction.
- pc_d  in  32  D PC.
- rs_val_d  in  32  forwarded rs value, the jr/jalr target.
- ab_cmp  in  3  rs vs rt flags: [2] gt, [1] eq, [0] lt.
- a0_cmp  in  3  rs vs 0 flags, same encoding.
- ext_sel  out  1  sign-extend for lw, sw, slti, sltiu.
- b_j_jr_sel  out  2  2 = jr/jalr, 1 = j/jal, 0 = other.
- redirect_d  out  1  override next fetch PC; flush F.
- redirect_pc_d  out  32  correct next PC when redirect_d = 1.

## Operation
- Instruction decode:
  - beq (op 4), bne (op 5), blez (op 6), bgtz (op 7).
  - bltz and bgez: op 1 with rt = 0 and rt = 1 respectively.
  - j (op 2), jal (op 3).
  - jr and jalr: op 0 with funct 8 and funct 9 respectively.
- Conditional outcome:
  - beq: eq. bne: !eq.
  - bgez: gt | eq. bgtz: gt.
  - blez: lt | eq. bltz: lt.
  - beq and bne use ab_cmp; the other four use a0_cmp.
- Target computation:
  - Conditional branch: pc_d + 4 + (sext(imm16) << 2).
  - j/jal: {pc_d[31:28], idx26, 2'b00}.
  - jr/jalr: rs_val_d.
- BTB entry fields: valid, tag = PC[31:IDX_W+2], target[31:0], counter[CNT_W-1:0].
- The lookup is combinational on pc_f.
- F-to-D pipeline register holds pred_d and ptgt_d:
  - Loads pred_taken_f and pred_target_f when !stall_d.
  - Clears to 0 when redirect_d = 1 (bubble).
- Actual next PC:
  - Taken conditional branch or any jump: the target above.
  - Everything else: pc_d + 4.
- redirect_d = valid_d & !stall_d & (X), where X is any one of:
  - a conditional branch with taken != pred_d;
  - taken with ptgt_d != target;
  - j/jal with !pred_d;
  - any jr/jalr;
  - a non-control-flow instruction with pred_d = 1.
- BTB update happens only when valid_d & !stall_d:
  - Cond branch, hit: counter +1 if taken, -1 if not, saturating at 0 and 2^CNT_W-1; target rewritten.
  - Cond branch, miss, taken: allocate; counter = 2^(CNT_W-1) (weakly taken); overwrite victim.
  - Cond branch, miss, not taken: no change.
  - j/jal: allocate or overwrite with counter = all-ones.
  - jr/jalr: never allocate.
  - Non-control-flow instruction with pred_d = 1: clear that entry's valid bit.

## Timing
- Reset, asynchronous:
  - All valid bits are 0 and counters are 2^(CNT_W-1)-1.
  - pred_d = 0 and ptgt_d = 0.
  - Outputs: pred_taken_f = 0, pred_target_f = 0, redirect_d = 0. redirect_pc_d, ext_sel and b_j_jr_sel follow their inputs.
- Reset asserted mid-operation discards all BTB state immediately.
- Prediction is combinational, available the same cycle as pc_f.
- Resolution is combinational in D. A mispredict costs exactly 1 bubble.
- BTB write occurs on the rising edge ending the resolving cycle.
- Same-cycle read and write of one index: the read returns the old contents, with no bypass. The new value is visible the next cycle.
- stall_d = 1 blocks redirect_d and updates, and holds pred_d and ptgt_d.
- valid_d = 0 blocks redirect_d and updates.

## Configuration
- BPRED_STATS_EN defined:
  - Adds outputs br_cnt[31:0] and miss_cnt[31:0].
  - br_cnt increments on each resolved control-flow instruction (valid_d & !stall_d).
  - miss_cnt increments on each cycle with redirect_d = 1.
  - Both wrap from 0xFFFFFFFF to 0 and reset to 0.
- BPRED_STATS_EN undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Cold start:
  - Stimulus: beq at pc_d=0x00003000, imm=0x0004, eq=1, pred_d=0.
  - Response: redirect_d=1, redirect_pc_d=0x00003014. Next cycle, pc_f=0x00003000 gives pred_taken_f=1 and pred_target_f=0x00003014 (counter 2).
- Saturation:
  - Stimulus: the same beq resolved taken 4 more times.
  - Response: counter holds at 3, with no redirect on any of them. Then three not-taken resolutions take the counter 3→2→1→0, and only the first of these redirects to 0x00003004.
- Not-taken miss:
  - Stimulus: bne with eq=1, cold BTB.
  - Response: redirect_d=0, no allocation; pred_taken_f stays 0 for that PC.
- Jumps:
  - Stimulus: jal at 0x00003100 with idx26=0x0000C80.
  - Response: first pass redirects to 0x00003200; second pass gives pred_taken_f=1 and no redirect.
  - Stimulus: jr with rs_val_d=0x00003400.
  - Response: redirect_d=1 every time, never allocated.
- Stall and reset:
  - Stimulus: a mispredicting branch with stall_d=1 for 3 cycles.
  - Response: redirect_d=0 throughout and no update; redirect_d=1 only in the first unstalled cycle.
  - Stimulus: rst_n low mid-stream.
  - Response: pred_taken_f=0 immediately.
- Stats (BPRED_STATS_EN):
  - Stimulus: the sequence of test 1 followed by test 2.
  - Response: br_cnt=5 and miss_cnt=1 after test 1 plus the taken resolutions of test 2.
